// File: rtl/mem_access_pkg.sv
// Shared encodings for the CPU-side memory access unit: access sizes,
// controller states, and the alignment/legality rule applied at accept time.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // An access faults when its size is illegal or its address is not naturally aligned.
    function automatic logic access_fault(input size_e size, input logic [1:0] lane);
        return (size == SIZE_ILLEGAL) ||
               ((size == SIZE_HALF) && lane[0]) ||
               ((size == SIZE_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: extracts and extends sub-word loads from a
// memory word, and merges sub-word store data into a memory word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        sign_extend,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    // A half-word always starts on lane 0 or lane 2.
    assign byte_shift = {lane, 3'b000};
    assign half_shift = {lane[1], 4'b0000};
    assign byte_val   = 8'(word >> byte_shift);
    assign half_val   = 16'(word >> half_shift);
    assign byte_mask  = 32'h0000_00ff << byte_shift;
    assign half_mask  = 32'h0000_ffff << half_shift;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        load_data   = word;
        merged_data = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data   = {{24{sign_extend & byte_val[7]}}, byte_val};
                merged_data = (word & ~byte_mask) | ({24'b0, wdata[7:0]} << byte_shift);
            end
            SIZE_HALF: begin
                load_data   = {{16{sign_extend & half_val[15]}}, half_val};
                merged_data = (word & ~half_mask) | ({16'b0, wdata[15:0]} << half_shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a CPU request port and a word-wide
// memory; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int addresswidth = 32,
    parameter int width        = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [31:0]             req_addr,
    input  logic [width-1:0]        req_wdata,
    output logic                    resp_valid,
    output logic [width-1:0]        resp_rdata,
    output logic                    resp_err,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_writeEnable,
    output logic [width-1:0]        mem_dataIn,
    input  logic [width-1:0]        mem_dataOut
);

    state_e      state, state_next;
    logic        write_q;
    size_e       size_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] data_in_q;
    logic [31:0] load_data;
    logic [31:0] merged_data;
    logic        accept;
    logic        fault;

    assign accept = req_valid && (state == IDLE);
    assign fault  = access_fault(size_e'(req_size), req_addr[1:0]);

    mem_lane_align u_lane_align (
        .word        (mem_dataOut),
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .sign_extend (signed_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            size_q    <= SIZE_BYTE;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            data_in_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                write_q  <= req_write;
                size_q   <= size_e'(req_size);
                signed_q <= req_signed;
                err_q    <= fault;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= '0;
                if (req_write && !fault && (size_e'(req_size) == SIZE_WORD))
                    data_in_q <= req_wdata;
            end
            // Memory presents the addressed word on the negedge inside READ.
            if (state == READ) begin
                if (write_q)
                    data_in_q <= merged_data;
                else
                    rdata_q <= load_data;
            end
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_err        = 1'b0;
        resp_rdata      = '0;
        mem_writeEnable = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault)
                        state_next = RESP;
                    else if (!req_write)
                        state_next = READ;
                    else if (size_e'(req_size) == SIZE_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:  state_next = write_q ? WRITE : RESP;
            WRITE: begin
                mem_writeEnable = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_address = addresswidth'(addr_q >> 2);
    assign mem_dataIn  = data_in_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter addresswidth, default 32, meaning the width of the memory word-address output.
REQ-002 SHALL have parameter width, default 32, meaning the data width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-009 req_signed  in  1  sign-extend sub-word loads.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  load result, extended.
REQ-014 resp_err  out  1  misaligned or illegal-size access, valid with resp_valid.
REQ-015 mem_address  out  addresswidth  word index, equal to req_addr[addresswidth+1:2].
REQ-016 mem_writeEnable  out  1  memory write strobe.
REQ-017 mem_dataIn  out  32  memory write data.
REQ-018 mem_dataOut  in  32  memory read data, registered by memory on negedge clk.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-020 SHALL register all request fields on the accept edge (req_valid && req_ready); inputs are ignored otherwise.
REQ-021 Accept in IDLE transitions as follows: misaligned or size 3 -> RESP with err; load -> READ; word store -> WRITE; byte/half store -> READ (read-modify-write).
REQ-022 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; such an access SHALL never assert mem_writeEnable.
REQ-023 READ lasts exactly one cycle; on its exit edge SHALL capture mem_dataOut; load -> RESP; sub-word store -> WRITE with merged word.
REQ-024 Byte lanes are little-endian: lane = addr[1:0]; half uses lanes {addr[1],0}+1..{addr[1],0}.
REQ-025 Merge SHALL replace only the addressed lane(s) of the captured word with req_wdata[7:0] or [15:0]; other lanes unchanged.
REQ-026 WRITE lasts exactly one cycle with mem_writeEnable=1 and stable mem_address/mem_dataIn, then -> RESP.
REQ-027 RESP lasts one cycle with resp_valid=1, then -> IDLE; no backpressure.
REQ-028 Load result: byte/half extracted from lane(s), zero- or sign-extended per req_signed; word unchanged.
REQ-029 Latency from accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-030 mem_writeEnable SHALL be 1 only in WRITE; resp_rdata SHALL be 0 for stores and errors.
REQ-031 Back-to-back requests: req_ready rises the cycle after RESP; at most one access is outstanding.

Reset
REQ-032 reset_n low SHALL immediately force state=IDLE, mem_writeEnable=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_dataIn=0.
REQ-033 Reset mid-operation SHALL abort the access with no response; a WRITE cycle cut by reset before negedge produces no memory write.
REQ-034 req_ready SHALL be 1 in the first cycle after reset_n deasserts.

Structure
REQ-035 Shared package mem_access_pkg SHALL hold size encodings (SIZE_BYTE/HALF/WORD) and FSM state encodings.
REQ-036 Lane extract/merge logic SHALL be one combinational sub-module mem_lane_align; FSM and registers stay in mem_access_unit.

Verification
REQ-037 Word load 0x10, memory[4]=0xDEADBEEF -> resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-038 Signed byte load 0x13, memory[4]=0x80112233 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Half store 0x22, data 0xABCD, memory[8]=0x11223344 -> one write pulse, memory[8]=0xABCD3344, resp at 3 cycles.
REQ-040 Word store to 0x06 -> resp_err=1 after 1 cycle, mem_writeEnable never high, memory unchanged.
REQ-041 reset_n pulled low during WRITE before negedge -> no memory change, no resp_valid, req_ready=1 after release.
REQ-042 Two back-to-back word stores to 0x0 then 0x4 -> both written, exactly two resp_valid pulses, no overlap.
